// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Bridges the MEM pipeline stage to a word-indexed data memory. Byte-addressed
// RV32 loads and stores become full-word memory accesses:
//   - loads: the word is read, shifted down to the addressed byte lane and
//     sign/zero extended (little-endian);
//   - SB/SH: read-modify-write, so bytes outside the addressed lanes are kept;
//   - SW aligned: single write.
// The request side is valid/ready (ready only while idle); the response is a
// one-cycle pulse with no backpressure. Illegal types fault without touching
// memory.
//
// Build option: LSU_MISALIGN_SPLIT_EN
//   defined     - misaligned H/W of a legal type is split into two word
//                 accesses (word i, then word i+1, wrapping at the top index).
//   not defined - misaligned H/W faults; RD1/WR1 are never entered.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (accept = valid & ready)
//   req_we              1 store, 0 load
//   req_type            funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr            byte address
//   req_wdata           store data, lane 0 aligned
//   rsp_valid           one-cycle completion pulse
//   rsp_data            extended load data, 0 for stores and faults
//   rsp_fault           illegal type or misaligned access
//   memRead/memWrite    memory strobes, never high together
//   memType             always 3'b010 (full-word accesses)
//   memAddr             {zeros, word index}
//   memWrData           merged write word
//   memDataOut          combinational read data from memory
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_IDX_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_fault,
    output logic              memRead,
    output logic              memWrite,
    output logic [2:0]        memType,
    output logic [31:0]       memAddr,
    output logic [31:0]       memWrData,
    input  logic [31:0]       memDataOut
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_WR0  = 3'd3,
        ST_WR1  = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    // Shift a (possibly two-word) read window down to the addressed byte and extend.
    function automatic logic [31:0] load_extend(input logic [2:0]  typ,
                                                input logic [63:0] pair,
                                                input logic [1:0]  off);
        logic [63:0] sh;
        sh = pair >> {off, 3'b000};
        case (typ)
            3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_extend = {24'h000000, sh[7:0]};
            3'b101:  load_extend = {16'h0000, sh[15:0]};
            default: load_extend = sh[31:0];
        endcase
    endfunction

    // Insert store data into the read window; lanes outside the access are kept.
    function automatic logic [63:0] store_merge(input logic [63:0] pair,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  typ,
                                                input logic [1:0]  off);
        logic [63:0] mask;
        logic [63:0] data;
        case (typ[1:0])
            2'b00:   mask = 64'h0000_0000_0000_00FF;
            2'b01:   mask = 64'h0000_0000_0000_FFFF;
            default: mask = 64'h0000_0000_FFFF_FFFF;
        endcase
        mask = mask << {off, 3'b000};
        data = {32'h0000_0000, wdata} << {off, 3'b000};
        store_merge = (pair & ~mask) | (data & mask);
    endfunction

    state_t                 state_r, state_s;
    logic                   we_r, we_s;
    logic [2:0]             type_r, type_s;
    logic [1:0]             off_r, off_s;
    logic [MEM_IDX_W-1:0]   idx_r, idx_s;
    logic [31:0]            wdata_r, wdata_s;
    logic                   split_r, split_s;
    logic                   fault_r, fault_s;
    logic [31:0]            word0_r, word0_s;
    logic [31:0]            hi_r, hi_s;

    logic                   req_ready_r, req_ready_s;
    logic                   rsp_valid_r, rsp_valid_s;
    logic [31:0]            rsp_data_r, rsp_data_s;
    logic                   rsp_fault_r, rsp_fault_s;
    logic                   mem_read_r, mem_read_s;
    logic                   mem_write_r, mem_write_s;
    logic [2:0]             mem_type_r;
    logic [MEM_IDX_W-1:0]   mem_idx_r, mem_idx_s;
    logic [31:0]            mem_wr_data_r, mem_wr_data_s;

    logic                   req_fault_s;
    logic                   req_split_s;
    logic [63:0]            rd_pair_s;
    logic [63:0]            merged_s;
    logic [31:0]            loaded_s;
    logic                   unused_addr_s;

    // Address bits above the word index do not select memory.
    assign unused_addr_s = ^req_addr[ADDR_W-1:MEM_IDX_W+2];

    // In RD1 the previous word is the low half of the window; otherwise only the current word matters.
    assign rd_pair_s = (state_r == ST_RD1) ? {memDataOut, word0_r} : {32'h0000_0000, memDataOut};
    assign merged_s  = store_merge(rd_pair_s, wdata_r, type_r, off_r);
    assign loaded_s  = load_extend(type_r, rd_pair_s, off_r);

    // Classify the incoming request: illegal type, misaligned fault or split.
    always_comb begin
        logic legal;
        logic misaligned;
        case (req_type)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~req_we;
            default:                legal = 1'b0;
        endcase
        case (req_type[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        req_fault_s = ~legal | (misaligned & ~SPLIT_EN);
        req_split_s = legal & misaligned & SPLIT_EN;
    end

    // Next-state and next-output logic; outputs are precomputed for the state being entered.
    always_comb begin
        state_s       = state_r;
        we_s          = we_r;
        type_s        = type_r;
        off_s         = off_r;
        idx_s         = idx_r;
        wdata_s       = wdata_r;
        split_s       = split_r;
        fault_s       = fault_r;
        word0_s       = word0_r;
        hi_s          = hi_r;
        mem_idx_s     = mem_idx_r;
        mem_wr_data_s = mem_wr_data_r;
        rsp_data_s    = 32'h0000_0000;

        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    we_s      = req_we;
                    type_s    = req_type;
                    off_s     = req_addr[1:0];
                    idx_s     = req_addr[MEM_IDX_W+1:2];
                    wdata_s   = req_wdata;
                    split_s   = req_split_s;
                    fault_s   = req_fault_s;
                    mem_idx_s = req_addr[MEM_IDX_W+1:2];
                    if (req_fault_s) begin
                        state_s = ST_RESP;
                    end else if (req_we && (req_type == 3'b010) && !req_split_s) begin
                        // Aligned full-word store needs no read.
                        state_s       = ST_WR0;
                        mem_wr_data_s = req_wdata;
                    end else begin
                        state_s = ST_RD0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD0: begin
                word0_s = memDataOut;
                if (split_r) begin
                    state_s   = ST_RD1;
                    mem_idx_s = idx_r + MEM_IDX_W'(1);
                end else if (we_r) begin
                    state_s       = ST_WR0;
                    mem_wr_data_s = merged_s[31:0];
                end else begin
                    state_s    = ST_RESP;
                    rsp_data_s = loaded_s;
                end
            end
            ST_RD1: begin
                if (we_r) begin
                    state_s       = ST_WR0;
                    mem_idx_s     = idx_r;
                    mem_wr_data_s = merged_s[31:0];
                    hi_s          = merged_s[63:32];
                end else begin
                    state_s    = ST_RESP;
                    rsp_data_s = loaded_s;
                end
            end
            ST_WR0: begin
                if (split_r) begin
                    state_s       = ST_WR1;
                    mem_idx_s     = idx_r + MEM_IDX_W'(1);
                    mem_wr_data_s = hi_r;
                end else begin
                    state_s = ST_RESP;
                end
            end
            ST_WR1: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        req_ready_s = (state_s == ST_IDLE);
        rsp_valid_s = (state_s == ST_RESP);
        rsp_fault_s = (state_s == ST_RESP) & fault_s;
        mem_read_s  = (state_s == ST_RD0) | (state_s == ST_RD1);
        mem_write_s = (state_s == ST_WR0) | (state_s == ST_WR1);
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            we_r          <= 1'b0;
            type_r        <= 3'b000;
            off_r         <= 2'b00;
            idx_r         <= '0;
            wdata_r       <= 32'h0000_0000;
            split_r       <= 1'b0;
            fault_r       <= 1'b0;
            word0_r       <= 32'h0000_0000;
            hi_r          <= 32'h0000_0000;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= 32'h0000_0000;
            rsp_fault_r   <= 1'b0;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_type_r    <= 3'b010;
            mem_idx_r     <= '0;
            mem_wr_data_r <= 32'h0000_0000;
        end else begin
            state_r       <= state_s;
            we_r          <= we_s;
            type_r        <= type_s;
            off_r         <= off_s;
            idx_r         <= idx_s;
            wdata_r       <= wdata_s;
            split_r       <= split_s;
            fault_r       <= fault_s;
            word0_r       <= word0_s;
            hi_r          <= hi_s;
            req_ready_r   <= req_ready_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_data_r    <= rsp_data_s;
            rsp_fault_r   <= rsp_fault_s;
            mem_read_r    <= mem_read_s;
            mem_write_r   <= mem_write_s;
            mem_type_r    <= 3'b010;
            mem_idx_r     <= mem_idx_s;
            mem_wr_data_r <= mem_wr_data_s;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_fault = rsp_fault_r;
    assign memRead   = mem_read_r;
    assign memWrite  = mem_write_r;
    assign memType   = mem_type_r;
    assign memAddr   = {{(32-MEM_IDX_W){1'b0}}, mem_idx_r};
    assign memWrData = mem_wr_data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Drives load_store_unit against a word memory model and compares every
// response with a byte-level reference model (little-endian, per-byte reads
// and writes into a shadow memory). Directed cases cover the documented
// examples, back-to-back handshaking and reset in the middle of a write;
// the rest is random traffic around index 0 and the top index (wrap).
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  memType;
    logic [31:0] memAddr;
    logic [31:0] memWrData;
    logic [31:0] memDataOut;

    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int acc_cnt  = 0;
    int viol_cnt = 0;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_fault  (rsp_fault),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .memType    (memType),
        .memAddr    (memAddr),
        .memWrData  (memWrData),
        .memDataOut (memDataOut)
    );

    always #5 clk = ~clk;

    assign memDataOut = mem[memAddr[15:0]];

    // Memory write port plus strobe/handshake counters (pre-edge values).
    always @(posedge clk) begin
        if (memWrite) begin
            mem[memAddr[15:0]] = memWrData;
            wr_cnt = wr_cnt + 1;
        end
        if (memRead) rd_cnt = rd_cnt + 1;
        if (req_valid && req_ready) acc_cnt = acc_cnt + 1;
    end

    // Protocol watch: exclusive strobes, no strobe while idle/responding, upper memAddr zero.
    always @(negedge clk) begin
        if (memRead && memWrite) viol_cnt = viol_cnt + 1;
        if ((memRead || memWrite) && (req_ready || rsp_valid)) viol_cnt = viol_cnt + 1;
        if (memAddr[31:16] != 16'h0000) viol_cnt = viol_cnt + 1;
        if (memType != 3'b010) viol_cnt = viol_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        w = ref_mem[a[17:2]];
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    // Reference: byte-wise access rules, expected latency and write count.
    task automatic ref_txn(input logic we, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] wd, output logic fault, output logic [31:0] data,
                           output int lat, output int nwr);
        int          size;
        bit          legal;
        bit          mis;
        logic [31:0] v;
        logic [31:0] ba;
        size  = (t[1:0] == 2'b00) ? 1 : ((t[1:0] == 2'b01) ? 2 : 4);
        legal = we ? (t == 3'b000 || t == 3'b001 || t == 3'b010)
                   : (t == 3'b000 || t == 3'b001 || t == 3'b010 || t == 3'b100 || t == 3'b101);
        mis   = (a % size) != 0;
        data  = 32'h0;
        nwr   = 0;
        fault = !legal || (mis && !SPLIT_EN);
        if (fault) begin
            lat = 1;
        end else if (!we) begin
            v = 32'h0;
            for (int k = 0; k < size; k++) begin
                ba = a + k;
                v  = v | (32'(ref_byte(ba)) << (8 * k));
            end
            if (size == 1)      data = t[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            else if (size == 2) data = t[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            else                data = v;
            lat = mis ? 3 : 2;
        end else begin
            for (int k = 0; k < size; k++) begin
                ba = a + k;
                ref_mem[ba[17:2]][{ba[1:0], 3'b000} +: 8] = wd[8*k +: 8];
            end
            lat = mis ? 5 : ((size == 4) ? 2 : 3);
            nwr = mis ? 2 : 1;
        end
    endtask

    task automatic run_txn(input logic we, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] got_data, output int got_lat);
        logic        e_fault;
        logic [31:0] e_data;
        int          e_lat, e_nwr, s_acc, s_wr, n;
        logic [15:0] w0;
        ref_txn(we, t, a, wd, e_fault, e_data, e_lat, e_nwr);
        @(negedge clk);
        req_we = we; req_type = t; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        s_acc = acc_cnt; s_wr = wr_cnt; n = 0;
        while (acc_cnt == s_acc && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("accept", 32'(acc_cnt != s_acc), 32'd1);
        req_valid = 1'b0;
        got_lat = 1;
        while (!rsp_valid && got_lat < 20) begin
            @(posedge clk); #1; got_lat++;
        end
        got_data = rsp_data;
        check("rsp_seen", 32'(rsp_valid), 32'd1);
        check("latency", got_lat, e_lat);
        check("rsp_fault", 32'(rsp_fault), 32'(e_fault));
        check("rsp_data", rsp_data, e_data);
        @(posedge clk); #1;
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("ready_after", 32'(req_ready), 32'd1);
        check("wr_pulses", wr_cnt - s_wr, e_nwr);
        w0 = a[17:2];
        check("mem_w0", mem[w0], ref_mem[w0]);
        check("mem_w1", mem[w0 + 16'd1], ref_mem[w0 + 16'd1]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, wd, r, a;
        logic [2:0]  t;
        logic [15:0] idx;
        logic        we, e_fault;
        logic [31:0] e_data;
        int          lat, e_lat, e_nwr, s_acc, s_wr, s_rd, n, seen;

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = $urandom();
            ref_mem[i] = mem[i];
        end
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_type = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_strobes", {30'h0, memRead, memWrite}, 32'h0);
        check("rst_mem_type", 32'(memType), 32'h2);
        check("rst_mem_addr", memAddr, 32'h0);
        check("rst_mem_wdata", memWrData, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Byte loads with sign and zero extension.
        mem[5] = 32'h8899AABB; ref_mem[5] = mem[5];
        run_txn(1'b0, 3'b000, 32'h15, 32'h0, d, lat);
        check("lb_data", d, 32'hFFFFFFAA);
        check("lb_lat", lat, 2);
        run_txn(1'b0, 3'b100, 32'h15, 32'h0, d, lat);
        check("lbu_data", d, 32'h000000AA);

        // Byte store keeps the other lanes.
        mem[5] = 32'h11223344; ref_mem[5] = mem[5];
        s_wr = wr_cnt;
        run_txn(1'b1, 3'b000, 32'h16, 32'h000000EE, d, lat);
        check("sb_mem", mem[5], 32'h11EE3344);
        check("sb_pulses", wr_cnt - s_wr, 1);
        check("sb_lat", lat, 3);

        // Misaligned half and word loads.
        mem[4] = 32'hDDCCBBAA; ref_mem[4] = mem[4];
        mem[5] = 32'h44332211; ref_mem[5] = mem[5];
        s_rd = rd_cnt; s_wr = wr_cnt;
        run_txn(1'b0, 3'b001, 32'h13, 32'h0, d, lat);
        check("lh_mis_data", d, SPLIT_EN ? 32'h000011DD : 32'h0);
        check("lh_mis_lat", lat, SPLIT_EN ? 3 : 1);
        check("lh_mis_reads", rd_cnt - s_rd, SPLIT_EN ? 2 : 0);
        check("lh_mis_writes", wr_cnt - s_wr, 0);
        run_txn(1'b0, 3'b010, 32'h12, 32'h0, d, lat);
        check("lw_mis_data", d, SPLIT_EN ? 32'h2211DDCC : 32'h0);
        check("lw_mis_lat", lat, SPLIT_EN ? 3 : 1);

        // Back-to-back SW then LW to the same word with req_valid held.
        wd = $urandom();
        ref_txn(1'b1, 3'b010, 32'h24, wd, e_fault, e_data, e_lat, e_nwr);
        ref_txn(1'b0, 3'b010, 32'h24, 32'h0, e_fault, e_data, e_lat, e_nwr);
        @(negedge clk);
        req_we = 1'b1; req_type = 3'b010; req_addr = 32'h24; req_wdata = wd; req_valid = 1'b1;
        s_acc = acc_cnt; n = 0;
        while (acc_cnt == s_acc && n < 20) begin @(posedge clk); #1; n++; end
        check("b2b_sw_accept", 32'(acc_cnt != s_acc), 32'd1);
        req_we = 1'b0; req_wdata = 32'h0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            check("b2b_ready_low", 32'(req_ready), 32'd0);
            @(posedge clk); #1; n++;
        end
        check("b2b_sw_lat", n + 1, 2);
        check("b2b_ready_in_resp", 32'(req_ready), 32'd0);
        s_acc = acc_cnt; n = 0;
        while (acc_cnt == s_acc && n < 20) begin @(posedge clk); #1; n++; end
        check("b2b_accept_gap", n, 2);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("b2b_lw_data", rsp_data, wd);
        check("b2b_lw_model", rsp_data, e_data);

        // Reset while an SB sits in its write cycle.
        d = mem[5];
        @(negedge clk);
        req_we = 1'b1; req_type = 3'b000; req_addr = 32'h16; req_wdata = 32'h55; req_valid = 1'b1;
        s_acc = acc_cnt; s_wr = wr_cnt; n = 0;
        while (acc_cnt == s_acc && n < 20) begin @(posedge clk); #1; n++; end
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_wr_strobe", 32'(memWrite), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_wr_drop", 32'(memWrite), 32'd0);
        seen = 0;
        repeat (2) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        repeat (4) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        check("rst_mid_no_rsp", seen, 0);
        check("rst_mid_no_write", wr_cnt - s_wr, 0);
        check("rst_mid_mem", mem[5], d);

        // Random traffic near index 0 and the top index.
        for (int i = 0; i < 250; i++) begin
            r   = $urandom();
            idx = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(65532, 65535));
            a   = {r[31:18], idx, r[1:0]};
            t   = 3'($urandom_range(0, 7));
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom();
            run_txn(we, t, a, wd, d, lat);
        end

        check("protocol_violations", viol_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
